// File: rtl/board_decimal_entry_pkg.sv
// Shared types and constants for the push-button decimal entry block.
// Holds the FSM encoding, cursor/BCD limits and the digit arithmetic helpers.
package board_decimal_entry_pkg;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    localparam logic [1:0] CURSOR_THOUSANDS = 2'd3;
    localparam logic [1:0] CURSOR_ONES      = 2'd0;
    localparam logic [3:0] BCD_MAX          = 4'd9;
    localparam int         ACC_W            = 14;
    localparam int         DATA_W           = 16;

    // 9999 fits in 14 bits, so the truncating shifts never lose information.
    function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] acc,
                                                  input logic [3:0]       digit);
        return (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] digit);
        return (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/board_decimal_entry_key_debounce.sv
// Per-key debouncer: a down-counter reloaded while the raw key is low.
// Emits a single registered press pulse after DEBOUNCE_CYCLES stable-high samples.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        press_q;
    logic        press_d;

    // Counter parks at zero while the key stays held, which blocks auto-repeat.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!raw) begin
            cnt_d = DEBOUNCE_CYCLES;
        end else if (cnt_q != 16'd0) begin
            cnt_d   = cnt_q - 16'd1;
            press_d = (cnt_q == 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= DEBOUNCE_CYCLES;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/board_decimal_entry.sv
// Push-button decimal entry: edits four BCD digits, converts them to binary on
// enter and hands the result to the RAM write port over valid/ready.
//
// state   | meaning
// EDIT    | key presses edit digits / cursor; enter starts conversion
// CONVERT | four acc = acc*10 + digit steps, thousands first
// WRITE   | wr_valid held with wr_data until wr_ready accepts it
module board_decimal_entry
    import board_decimal_entry_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_inc,
    input  logic                key_next,
    input  logic                key_clear,
    input  logic                key_enter,
    input  logic                wr_ready,
    output logic                wr_valid,
    output logic [DATA_W-1:0]   wr_data,
    output logic [3:0]          digit_1000,
    output logic [3:0]          digit_100,
    output logic [3:0]          digit_10,
    output logic [3:0]          digit_1,
    output logic [1:0]          cursor,
    output logic                busy
);

    logic press_inc;
    logic press_next;
    logic press_clear;
    logic press_enter;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk   (clk),
        .reset (reset),
        .raw   (key_inc),
        .press (press_inc)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk   (clk),
        .reset (reset),
        .raw   (key_next),
        .press (press_next)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (key_clear),
        .press (press_clear)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
        .clk   (clk),
        .reset (reset),
        .raw   (key_enter),
        .press (press_enter)
    );

    state_e                  state_q,    state_d;
    logic [3:0][3:0]         digits_q,   digits_d;
    logic [1:0]              cursor_q,   cursor_d;
    logic [1:0]              idx_q,      idx_d;
    logic [ACC_W-1:0]        acc_q,      acc_d;
    logic [ACC_W-1:0]        acc_next;
    logic                    wr_valid_q, wr_valid_d;
    logic [DATA_W-1:0]       wr_data_q,  wr_data_d;
    logic                    busy_q,     busy_d;

    assign acc_next = acc_step(acc_q, digits_q[idx_q]);

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        cursor_d   = cursor_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        case (state_q)
            EDIT: begin
                // Only the highest-priority press of a cycle is acted on.
                if (press_clear) begin
                    digits_d = '0;
                    cursor_d = CURSOR_THOUSANDS;
                end else if (press_enter) begin
                    acc_d   = '0;
                    idx_d   = CURSOR_THOUSANDS;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end else if (press_next) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (press_inc) begin
                    digits_d[cursor_q] = bcd_inc(digits_q[cursor_q]);
                end
            end

            CONVERT: begin
                acc_d = acc_next;
                idx_d = idx_q - 2'd1;
                if (idx_q == CURSOR_ONES) begin
                    wr_data_d  = {{(DATA_W-ACC_W){1'b0}}, acc_next};
                    wr_valid_d = 1'b1;
                    state_d    = WRITE;
                end
            end

            WRITE: begin
                if (wr_valid_q && wr_ready) begin
                    wr_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    digits_d   = '0;
                    cursor_d   = CURSOR_THOUSANDS;
                    state_d    = EDIT;
                end
            end

            default: begin
                wr_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = EDIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EDIT;
            digits_q   <= '0;
            cursor_q   <= CURSOR_THOUSANDS;
            idx_q      <= CURSOR_THOUSANDS;
            acc_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            cursor_q   <= cursor_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign digit_1000 = digits_q[3];
    assign digit_100  = digits_q[2];
    assign digit_10   = digits_q[1];
    assign digit_1    = digits_q[0];
    assign cursor     = cursor_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_board_decimal_entry.sv
// Self-checking bench for board_decimal_entry with a short debounce window.
// A digit/cursor model computed with plain arithmetic supplies every expected value.
module tb_board_decimal_entry;

    localparam logic [15:0] DEB = 16'd4;
    localparam int          N   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_inc, key_next, key_clear, key_enter;
    logic        wr_ready;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic [3:0]  digit_1000, digit_100, digit_10, digit_1;
    logic [1:0]  cursor;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_dig[4];
    int m_cur;
    int xfers    = 0;

    always #5 clk = ~clk;

    board_decimal_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_inc    (key_inc),
        .key_next   (key_next),
        .key_clear  (key_clear),
        .key_enter  (key_enter),
        .wr_ready   (wr_ready),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .digit_1000 (digit_1000),
        .digit_100  (digit_100),
        .digit_10   (digit_10),
        .digit_1    (digit_1),
        .cursor     (cursor),
        .busy       (busy)
    );

    always @(posedge clk) if (!reset && wr_valid && wr_ready) xfers++;

    logic [17:0] act_disp;
    assign act_disp = {digit_1000, digit_100, digit_10, digit_1, cursor};

    function automatic logic [17:0] exp_disp();
        return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), 2'(m_cur)};
    endfunction

    function automatic int exp_value();
        return m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cur = 3;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // k: 0=inc, 1=next, 2=clear. Only used while the DUT is in EDIT.
    task automatic do_press(input int k);
        int h;
        h = N + $urandom_range(0, 3);
        case (k)
            0: key_inc = 1'b1;
            1: key_next = 1'b1;
            default: key_clear = 1'b1;
        endcase
        tick(h);
        key_inc = 1'b0; key_next = 1'b0; key_clear = 1'b0;
        tick(1 + $urandom_range(0, 2));
        case (k)
            0: m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            1: m_cur = (m_cur + 3) % 4;
            default: model_clear();
        endcase
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        int v[4];
        v[3] = d3; v[2] = d2; v[1] = d1; v[0] = d0;
        do_press(2);
        for (int p = 3; p >= 0; p--) begin
            repeat (v[p]) do_press(0);
            do_press(1);
        end
    endtask

    // Latencies counted in cycles from the cycle the raw enter key goes high.
    task automatic run_enter(output int lat_busy, output int lat_valid);
        lat_busy  = -1;
        lat_valid = -1;
        key_enter = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == N + 1) key_enter = 1'b0;
            if (busy && lat_busy < 0) lat_busy = c;
            if (wr_valid) begin
                lat_valid = c;
                break;
            end
        end
        key_enter = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_checks++;
        if (act_disp !== 18'h00003) begin
            n_fail++; $display("FAIL reset_disp got %h want %h", act_disp, 18'h00003);
        end
        n_checks++;
        if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        n_checks++;
        if (wr_data !== 16'd0) begin n_fail++; $display("FAIL reset_wr_data got %0d want 0", wr_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        model_clear();
        tick(2);
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL post_reset_disp got %h want %h", act_disp, exp_disp());
        end
    endtask

    task automatic test_entry_1234();
        int lb, lv, x0;
        wr_ready = 1'b1;
        do_press(2);
        for (int p = 1; p <= 4; p++) begin
            repeat (p) do_press(0);
            if (p < 4) do_press(1);
        end
        n_checks++;
        if (act_disp !== exp_disp() || act_disp !== {16'h1234, 2'd0}) begin
            n_fail++; $display("FAIL e1234_disp got %h want %h", act_disp, {16'h1234, 2'd0});
        end
        x0 = xfers;
        run_enter(lb, lv);
        n_checks++;
        if (lb !== N + 1) begin n_fail++; $display("FAIL e1234_busy_latency got %0d want %0d", lb, N + 1); end
        n_checks++;
        if (lv !== N + 5) begin n_fail++; $display("FAIL e1234_valid_latency got %0d want %0d", lv, N + 5); end
        n_checks++;
        if (wr_data !== 16'(exp_value())) begin
            n_fail++; $display("FAIL e1234_wr_data got %0d want %0d", wr_data, exp_value());
        end
        tick(1);
        model_clear();
        n_checks++;
        if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL e1234_valid_width got valid=%b busy=%b want 0 0", wr_valid, busy);
        end
        n_checks++;
        if (xfers - x0 !== 1) begin n_fail++; $display("FAIL e1234_xfers got %0d want 1", xfers - x0); end
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL e1234_cleared got %h want %h", act_disp, exp_disp());
        end
    endtask

    task automatic test_wrap();
        do_press(2);
        repeat (3) do_press(1);
        n_checks++;
        if (cursor !== 2'd0) begin n_fail++; $display("FAIL wrap_cursor0 got %0d want 0", cursor); end
        for (int i = 1; i <= 10; i++) begin
            do_press(0);
            n_checks++;
            if (digit_1 !== 4'(i % 10) || act_disp !== exp_disp()) begin
                n_fail++; $display("FAIL wrap_inc%0d got %0d want %0d", i, digit_1, i % 10);
            end
        end
        do_press(2);
        for (int i = 1; i <= 4; i++) begin
            do_press(1);
            n_checks++;
            if (cursor !== 2'((3 - i + 4) % 4)) begin
                n_fail++; $display("FAIL wrap_next%0d got %0d want %0d", i, cursor, (3 - i + 4) % 4);
            end
        end
    endtask

    task automatic test_stall_9999();
        int lb, lv, x0;
        wr_ready = 1'b0;
        set_digits(9, 9, 9, 9);
        x0 = xfers;
        run_enter(lb, lv);
        n_checks++;
        if (lv !== N + 5) begin n_fail++; $display("FAIL s9999_valid_latency got %0d want %0d", lv, N + 5); end
        for (int c = 0; c < 20; c++) begin
            if (c == 2)  key_inc = 1'b1;
            if (c == 9)  key_inc = 1'b0;
            if (c == 11) key_clear = 1'b1;
            if (c == 18) key_clear = 1'b0;
            n_checks++;
            if ({wr_valid, busy, wr_data} !== {1'b1, 1'b1, 16'd9999}) begin
                n_fail++; $display("FAIL s9999_hold%0d got v=%b b=%b d=%0d want 1 1 9999",
                                   c, wr_valid, busy, wr_data);
            end
            tick(1);
        end
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL s9999_keys_ignored got %h want %h", act_disp, exp_disp());
        end
        wr_ready = 1'b1;
        tick(1);
        model_clear();
        n_checks++;
        if (wr_valid !== 1'b0 || act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL s9999_release got v=%b disp=%h want 0 %h", wr_valid, act_disp, exp_disp());
        end
        tick(5);
        n_checks++;
        if (xfers - x0 !== 1) begin n_fail++; $display("FAIL s9999_xfers got %0d want 1", xfers - x0); end
    endtask

    task automatic test_bounce();
        do_press(2);
        key_inc = 1'b1; tick(N - 1);
        key_inc = 1'b0; tick(1);
        key_inc = 1'b1; tick(N - 1);
        key_inc = 1'b0; tick(3);
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL bounce_short got %h want %h", act_disp, exp_disp());
        end
        key_inc = 1'b1; tick(10);
        key_inc = 1'b0; tick(2);
        m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL bounce_long got %h want %h", act_disp, exp_disp());
        end
    endtask

    task automatic test_priority();
        int lb, lv;
        logic saw_busy;
        wr_ready = 1'b1;
        set_digits(5, 0, 7, 2);
        do_press(1);
        key_inc = 1'b1; key_next = 1'b1;
        run_enter(lb, lv);
        n_checks++;
        if (lb !== N + 1) begin n_fail++; $display("FAIL prio_enter_busy got %0d want %0d", lb, N + 1); end
        n_checks++;
        if (act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL prio_digits_kept got %h want %h", act_disp, exp_disp());
        end
        n_checks++;
        if (wr_data !== 16'(exp_value())) begin
            n_fail++; $display("FAIL prio_wr_data got %0d want %0d", wr_data, exp_value());
        end
        tick(1);
        key_inc = 1'b0; key_next = 1'b0;
        tick(2);
        model_clear();
        set_digits(3, 1, 4, 1);
        saw_busy = 1'b0;
        key_clear = 1'b1; key_enter = 1'b1;
        for (int c = 0; c < N + 4; c++) begin
            tick(1);
            if (c == N) begin key_clear = 1'b0; key_enter = 1'b0; end
            if (busy) saw_busy = 1'b1;
        end
        model_clear();
        n_checks++;
        if (saw_busy !== 1'b0 || act_disp !== exp_disp()) begin
            n_fail++; $display("FAIL prio_clear_over_enter got busy=%b disp=%h want 0 %h",
                               saw_busy, act_disp, exp_disp());
        end
    endtask

    task automatic test_random();
        int lb, lv, d, x0;
        for (int r = 0; r < 3; r++) begin
            do_press(2);
            for (int p = 0; p < 4; p++) begin
                repeat ($urandom_range(0, 12)) do_press(0);
                do_press(1);
            end
            d = $urandom_range(0, 5);
            wr_ready = (d == 0);
            x0 = xfers;
            run_enter(lb, lv);
            n_checks++;
            if (lv !== N + 5 || wr_data !== 16'(exp_value())) begin
                n_fail++; $display("FAIL rand%0d_value got lat=%0d data=%0d want %0d %0d",
                                   r, lv, wr_data, N + 5, exp_value());
            end
            tick(d);
            n_checks++;
            if (d > 0 && (wr_valid !== 1'b1 || wr_data !== 16'(exp_value()))) begin
                n_fail++; $display("FAIL rand%0d_hold got v=%b d=%0d want 1 %0d", r, wr_valid, wr_data, exp_value());
            end
            wr_ready = 1'b1;
            tick(1);
            model_clear();
            n_checks++;
            if (wr_valid !== 1'b0 || xfers - x0 !== 1 || act_disp !== exp_disp()) begin
                n_fail++; $display("FAIL rand%0d_done got v=%b x=%0d disp=%h want 0 1 %h",
                                   r, wr_valid, xfers - x0, act_disp, exp_disp());
            end
        end
    endtask

    task automatic test_reset_convert();
        int x0;
        logic saw_valid;
        wr_ready = 1'b1;
        set_digits(8, 6, 4, 2);
        x0 = xfers;
        key_enter = 1'b1;
        tick(N + 1);
        key_enter = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstconv_busy got %b want 1", busy); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (wr_valid) saw_valid = 1'b1;
            tick(1);
        end
        model_clear();
        n_checks++;
        if (saw_valid !== 1'b0 || xfers !== x0) begin
            n_fail++; $display("FAIL rstconv_no_write got valid=%b xfers=%0d want 0 0", saw_valid, xfers - x0);
        end
        n_checks++;
        if (act_disp !== exp_disp() || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstconv_state got disp=%h busy=%b want %h 0", act_disp, busy, exp_disp());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        key_inc = 1'b0; key_next = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
        wr_ready = 1'b0;
        model_clear();
        test_reset();
        test_entry_1234();
        test_wrap();
        test_stall_9999();
        test_bounce();
        test_priority();
        test_random();
        test_reset_convert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
